mmio_hub: RTL

//  Parametrised memory-mapped I/O hub on the CPU data bus: N byte-wide GPIO output/input ports,
//  a prescaled 16-bit down-counting timer with status flag and interrupt, and registered read-back.

---
 rtl/mmio_hub.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: byte-wide GPIO ports, optional prescaled down-counting timer, registered read-back.
// Timer logic is present only when MMIO_TIMER_EN is defined; otherwise its offsets read 0 and irq is tied low.
module mmio_hub #(
   parameter logic [15:0] BASE_ADDR  = 16'hff00,
   parameter int unsigned NUM_GPIO   = 2,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  write_enable,
   input  logic                  byte_select,
   input  logic                  byte_enable,
   input  logic [15:0]           addr,
   input  logic [15:0]           data_in,
   output logic [15:0]           data_out,
   output logic                  serviced_read,
   output logic [8*NUM_GPIO-1:0] gpio_out,
   input  logic [8*NUM_GPIO-1:0] gpio_in,
   output logic                  irq
);

   logic [15:0]           ba;
   logic [7:0]            off;
   logic [7:0]            off_hi;
   logic                  hit;
   logic                  word;
   logic                  wr;
   logic                  rd;
   logic                  unused_addr_msb;
   logic [8*NUM_GPIO-1:0] gpio_sync1;
   logic [8*NUM_GPIO-1:0] gpio_sync2;

`ifdef MMIO_TIMER_EN
   logic                  ctrl_en;
   logic                  ctrl_ar;
   logic                  ctrl_ie;
   logic                  expired;
   logic [15:0]           reload;
   logic [15:0]           count;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pcnt;
   logic                  ctrl_wr;
   logic [2:0]            ctrl_d;
   logic [4:0]            unused_ctrl_bits;
   logic                  status_clr;
   logic                  status_d;
   logic [6:0]            unused_status_bits;
   logic                  reload_wr;
   logic [15:0]           reload_nx;
   logic                  tick;
   logic                  expire;
`endif

   assign ba              = {addr[14:0], byte_select};
   assign unused_addr_msb = addr[15];
   assign off             = ba[7:0];
   assign off_hi          = {ba[7:1], 1'b1};
   assign hit             = (ba[15:8] == BASE_ADDR[15:8]);
   assign word            = ~byte_enable & ~byte_select;
   assign wr              = en & write_enable & hit;
   assign rd              = en & ~write_enable & hit;

   // A word write touches the even byte (low data) and the following odd byte (high data).
   function automatic logic wr_hit(input logic [7:0] o);
      return wr && ((off == o) || (word && off_hi == o));
   endfunction

   function automatic logic [7:0] wr_byte(input logic [7:0] o);
      return (word && off_hi == o) ? data_in[15:8] : data_in[7:0];
   endfunction

   function automatic logic [7:0] rd_byte(input logic [7:0] o);
      logic [7:0] v;
      v = '0;
      for (int unsigned k = 0; k < NUM_GPIO; k++) begin
         if (o == 8'(2*k))     v = gpio_out[8*k +: 8];
         if (o == 8'(2*k + 1)) v = gpio_sync2[8*k +: 8];
      end
`ifdef MMIO_TIMER_EN
      case (o)
         8'h10:   v = {5'b0, ctrl_ie, ctrl_ar, ctrl_en};
         8'h11:   v = {7'b0, expired};
         8'h12:   v = reload[7:0];
         8'h13:   v = reload[15:8];
         8'h14:   v = count[7:0];
         8'h15:   v = count[15:8];
         8'h16:   v = 8'(prescale);
         default: ;
      endcase
`endif
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_out <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_GPIO; k++) begin
            if (wr_hit(8'(2*k))) gpio_out[8*k +: 8] <= wr_byte(8'(2*k));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_sync1 <= '0;
         gpio_sync2 <= '0;
      end else begin
         gpio_sync1 <= gpio_in;
         gpio_sync2 <= gpio_sync1;
      end
   end

   // Both bytes of a word read come from the same cycle, so COUNT reads are atomic.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out      <= '0;
         serviced_read <= 1'b0;
      end else begin
         serviced_read <= rd;
         data_out      <= rd ? {(word ? rd_byte(off_hi) : 8'h00), rd_byte(off)} : '0;
      end
   end

`ifdef MMIO_TIMER_EN
   always_comb begin
      ctrl_wr                          = wr_hit(8'h10);
      {unused_ctrl_bits, ctrl_d}       = wr_byte(8'h10);
      {unused_status_bits, status_d}   = wr_byte(8'h11);
      status_clr                       = wr_hit(8'h11) & status_d;
      reload_wr                        = wr_hit(8'h12) | wr_hit(8'h13);
      reload_nx                        = {(wr_hit(8'h13) ? wr_byte(8'h13) : reload[15:8]),
                                          (wr_hit(8'h12) ? wr_byte(8'h12) : reload[7:0])};
      // A RELOAD write in the same cycle discards the tick entirely.
      tick                             = ctrl_en && (pcnt == prescale) && !reload_wr;
      expire                           = tick && (count == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_en  <= 1'b0;
         ctrl_ar  <= 1'b0;
         ctrl_ie  <= 1'b0;
         expired  <= 1'b0;
         reload   <= '0;
         count    <= '0;
         prescale <= '0;
         pcnt     <= '0;
         irq      <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            {ctrl_ie, ctrl_ar, ctrl_en} <= ctrl_d;
         end else if (expire && !ctrl_ar) begin
            ctrl_en <= 1'b0;
         end

         if (expire)          expired <= 1'b1;
         else if (status_clr) expired <= 1'b0;

         if (wr_hit(8'h16)) prescale <= PRESCALE_W'(wr_byte(8'h16));

         if (reload_wr) begin
            reload <= reload_nx;
            count  <= reload_nx;
         end else if (tick) begin
            if (count == '0) begin
               if (ctrl_ar) count <= reload;
            end else begin
               count <= count - 1'b1;
            end
         end

         if (reload_wr || (ctrl_wr && ctrl_d[0] && !ctrl_en) || tick) pcnt <= '0;
         else if (ctrl_en)                                               pcnt <= pcnt + 1'b1;

         irq <= expired & ctrl_ie;
      end
   end
`else
   assign irq = 1'b0;
`endif

endmodule
